// File: rtl/game_fsm_ctrl_if.sv
// Player-input and status/display signal bundle for the game-flow controller.
// master = input decoder/display side, slave = controller.
interface game_fsm_ctrl_if #(
  parameter int STEP_W = 8,
  parameter int TIME_W = 10
);
  logic              start_sw;
  logic              pause_sw;
  logic              win_flag;
  logic              active;
  logic              tick;
  logic [2:0]        game_status;
  logic [STEP_W-1:0] step_number;
  logic [TIME_W-1:0] elapsed_sec;
  logic              step_wrap;

  modport master (
    output start_sw, pause_sw, win_flag, active, tick,
    input  game_status, step_number, elapsed_sec, step_wrap
  );

  modport slave (
    input  start_sw, pause_sw, win_flag, active, tick,
    output game_status, step_number, elapsed_sec, step_wrap
  );
endinterface

// File: rtl/game_fsm_ctrl.sv
// Game-flow controller: board select / play / pause / win / lose phases plus move and play-time counters.
// Every output is registered one edge after its inputs; level/pulse inputs only, no backpressure.
module game_fsm_ctrl #(
  parameter int STEP_W     = 8,
  parameter int STEP_MAX   = 255,
  parameter int STEP_MODE  = 0,
  parameter int TIME_W     = 10,
  parameter int TIME_LIMIT = 0
) (
  input logic            clk_d,
  input logic            rst_n,
  game_fsm_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    CHOSE_BOARD  = 3'd0,
    GAME_INITIAL = 3'd1,
    GAMING       = 3'd2,
    PAUSED       = 3'd3,
    WINNED       = 3'd4,
    LOST         = 3'd5
  } state_t;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_MAX);
  localparam logic [STEP_W-1:0] STEP_PEN  = STEP_W'(STEP_MAX - 1);
  localparam logic [TIME_W-1:0] TIME_PEN  = TIME_W'(TIME_LIMIT - 1);
  localparam logic [TIME_W-1:0] TIME_TOP  = '1;

  state_t            state;
  logic [STEP_W-1:0] step_cnt;
  logic [TIME_W-1:0] sec_cnt;
  logic              wrap;

  logic   playing;
  logic   step_go;
  logic   tick_go;
  logic   step_lose;
  logic   time_lose;
  state_t resume;

  assign playing   = (state == GAME_INITIAL) || (state == GAMING);
  assign step_go   = playing && bus.active;
  assign tick_go   = playing && bus.tick;
  // Lose fires on the event that would make the counter reach its limit.
  assign step_lose = (STEP_MODE == 2) && step_go && (step_cnt == STEP_PEN);
  assign time_lose = (TIME_LIMIT != 0) && tick_go && (sec_cnt == TIME_PEN);
  assign resume    = (step_cnt == '0) ? GAME_INITIAL : GAMING;

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CHOSE_BOARD;
      step_cnt <= '0;
      sec_cnt  <= '0;
      wrap     <= 1'b0;
    end else if (!bus.start_sw) begin
      state    <= CHOSE_BOARD;
      step_cnt <= '0;
      sec_cnt  <= '0;
      wrap     <= 1'b0;
    end else begin
      case (state)
        WINNED, LOST: state <= state;
        GAME_INITIAL, GAMING: begin
          if (bus.win_flag)              state <= WINNED;
          else if (step_lose || time_lose) state <= LOST;
          else if (bus.pause_sw)         state <= PAUSED;
          else                           state <= resume;
        end
        PAUSED: begin
          if (bus.win_flag)      state <= WINNED;
          else if (bus.pause_sw) state <= PAUSED;
          else                   state <= resume;
        end
        CHOSE_BOARD: state <= resume;
        default:     state <= CHOSE_BOARD;
      endcase

      wrap <= 1'b0;
      if (step_go) begin
        if (step_cnt == STEP_LAST) begin
          if (STEP_MODE == 0) step_cnt <= '0;
          wrap <= (STEP_MODE != 2);
        end else begin
          step_cnt <= step_cnt + STEP_W'(1);
        end
      end

      if (tick_go && (sec_cnt != TIME_TOP)) sec_cnt <= sec_cnt + TIME_W'(1);
    end
  end

  assign bus.game_status = state;
  assign bus.step_number = step_cnt;
  assign bus.elapsed_sec = sec_cnt;
  assign bus.step_wrap   = wrap;

endmodule
